// File: rtl/br_ctrl.sv
// rtl/br_ctrl.sv - EX-stage branch resolution, redirect/flush sequencing and perf counters
module br_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ex_valid,
    input  logic [31:0]      i_ex_pc,
    input  logic [31:0]      i_ex_imm,
    input  logic [31:0]      i_rs1_data,
    input  logic [2:0]       i_funct3,
    input  logic             i_is_branch,
    input  logic             i_is_jal,
    input  logic             i_is_jalr,
    input  logic             i_pred_taken,
    input  logic [31:0]      i_pred_target,
    output logic             o_br_unsigned,
    input  logic             i_br_less,
    input  logic             i_br_equal,
    output logic             o_ex_accept,
    output logic             o_redirect_valid,
    output logic [31:0]      o_redirect_pc,
    input  logic             i_redirect_ready,
    output logic             o_flush,
    output logic             o_resolve_valid,
    output logic             o_resolve_taken,
    output logic [31:0]      o_resolve_pc,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt,
    input  logic             i_cnt_clr
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REDIRECT = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    logic [1:0]       r_state;
    logic [31:0]      r_fcnt;
    logic [31:0]      r_redirect_pc;
    logic             r_resolve_valid;
    logic             r_resolve_taken;
    logic [31:0]      r_resolve_pc;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic             w_is_cf;
    logic             w_br_taken;
    logic             w_taken;
    logic [31:0]      w_jalr_sum;
    logic [31:0]      w_target;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_actual_npc;
    logic [31:0]      w_pred_npc;
    logic             w_mispred;
    logic             w_resolve;

    assign o_br_unsigned = i_funct3[1];

    always_comb begin
        w_br_taken = 1'b0;
        case (i_funct3)
            3'b000:          w_br_taken = i_br_equal;
            3'b001:          w_br_taken = ~i_br_equal;
            3'b100, 3'b110:  w_br_taken = i_br_less;
            3'b101, 3'b111:  w_br_taken = ~i_br_less;
            default:         w_br_taken = 1'b0;
        endcase
    end

    assign w_is_cf      = i_is_branch | i_is_jal | i_is_jalr;
    assign w_taken      = i_is_jalr | i_is_jal | w_br_taken;
    assign w_jalr_sum   = i_rs1_data + i_ex_imm;
    assign w_target     = i_is_jalr ? {w_jalr_sum[31:1], 1'b0} : (i_ex_pc + i_ex_imm);
    assign w_pc_plus4   = i_ex_pc + 32'd4;
    assign w_actual_npc = w_taken ? w_target : w_pc_plus4;
    assign w_pred_npc   = i_pred_taken ? i_pred_target : w_pc_plus4;
    // Compare full next-PCs so a "taken" prediction to pc+4 is not a mispredict.
    assign w_mispred    = (w_actual_npc != w_pred_npc);
    assign w_resolve    = (r_state == ST_IDLE) & i_ex_valid & w_is_cf;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_IDLE;
            r_fcnt          <= 32'd0;
            r_redirect_pc   <= 32'd0;
            r_resolve_valid <= 1'b0;
            r_resolve_taken <= 1'b0;
            r_resolve_pc    <= 32'd0;
        end else begin
            r_resolve_valid <= w_resolve;
            case (r_state)
                ST_IDLE: begin
                    if (w_resolve) begin
                        r_resolve_taken <= w_taken;
                        r_resolve_pc    <= i_ex_pc;
                        if (w_mispred) begin
                            r_redirect_pc <= w_actual_npc;
                            r_state       <= ST_REDIRECT;
                        end
                    end
                end
                ST_REDIRECT: begin
                    if (i_redirect_ready) begin
                        if (FLUSH_CYCLES == 0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_FLUSH;
                            r_fcnt  <= 32'(FLUSH_CYCLES);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (r_fcnt <= 32'd1) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_fcnt <= r_fcnt - 32'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else if (w_resolve) begin
            if (r_br_cnt != '1) begin
                r_br_cnt <= r_br_cnt + 1'b1;
            end
            if (w_mispred && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
            end
        end
    end

    assign o_ex_accept      = (r_state == ST_IDLE);
    assign o_redirect_valid = (r_state == ST_REDIRECT);
    assign o_flush          = (r_state != ST_IDLE);
    assign o_redirect_pc    = r_redirect_pc;
    assign o_resolve_valid  = r_resolve_valid;
    assign o_resolve_taken  = r_resolve_taken;
    assign o_resolve_pc     = r_resolve_pc;
    assign o_br_cnt         = r_br_cnt;
    assign o_mispred_cnt    = r_mispred_cnt;

endmodule

// File: tb/tb_br_ctrl.sv
// tb/tb_br_ctrl.sv - scoreboard bench for br_ctrl (FLUSH_CYCLES=2, CNT_W=4)
module tb_br_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0, ex_imm = '0, rs1_data = '0, pred_target = '0;
    logic [2:0]  funct3 = '0;
    logic        is_branch = 1'b0, is_jal = 1'b0, is_jalr = 1'b0, pred_taken = 1'b0;
    logic        br_less = 1'b0, br_equal = 1'b0, redirect_ready = 1'b1, cnt_clr = 1'b0;
    logic        br_unsigned, ex_accept, redirect_valid, flush;
    logic        resolve_valid, resolve_taken;
    logic [31:0] redirect_pc, resolve_pc;
    logic [3:0]  br_cnt, mispred_cnt;

    int n_chk = 0;
    int n_err = 0;
    logic [32:0] q_res[$];
    logic [31:0] q_redir[$];
    logic        prev_rv = 1'b0;
    logic [31:0] prev_pc = '0;

    br_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ex_valid(ex_valid), .i_ex_pc(ex_pc),
        .i_ex_imm(ex_imm), .i_rs1_data(rs1_data), .i_funct3(funct3),
        .i_is_branch(is_branch), .i_is_jal(is_jal), .i_is_jalr(is_jalr),
        .i_pred_taken(pred_taken), .i_pred_target(pred_target),
        .o_br_unsigned(br_unsigned), .i_br_less(br_less), .i_br_equal(br_equal),
        .o_ex_accept(ex_accept), .o_redirect_valid(redirect_valid),
        .o_redirect_pc(redirect_pc), .i_redirect_ready(redirect_ready),
        .o_flush(flush), .o_resolve_valid(resolve_valid),
        .o_resolve_taken(resolve_taken), .o_resolve_pc(resolve_pc),
        .o_br_cnt(br_cnt), .o_mispred_cnt(mispred_cnt), .i_cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected resolve/redirect records whenever the DUT presents them.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rv = 1'b0;
        end else begin
            if (resolve_valid) begin
                if (q_res.size() == 0) begin
                    check("unexpected_resolve", {31'd0, resolve_valid}, 32'd0);
                end else begin
                    logic [32:0] e;
                    e = q_res.pop_front();
                    check("resolve_pc", resolve_pc, e[32:1]);
                    check("resolve_taken", {31'd0, resolve_taken}, {31'd0, e[0]});
                end
            end
            if (redirect_valid) begin
                if (!prev_rv) begin
                    if (q_redir.size() == 0) begin
                        check("unexpected_redirect", {31'd0, redirect_valid}, 32'd0);
                    end else begin
                        check("redirect_pc", redirect_pc, q_redir.pop_front());
                    end
                end else begin
                    check("redirect_pc_stable", redirect_pc, prev_pc);
                end
            end
            prev_rv = redirect_valid;
            prev_pc = redirect_pc;
        end
    end

    task automatic issue(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                         input logic less, input logic eq, input logic pt, input logic [31:0] ptgt,
                         input logic exp_taken, input logic exp_mis, input logic [31:0] exp_npc);
        ex_valid = 1'b1; is_branch = br; is_jal = jal; is_jalr = jalr; funct3 = f3;
        ex_pc = pc; ex_imm = imm; rs1_data = rs1; br_less = less; br_equal = eq;
        pred_taken = pt; pred_target = ptgt;
        if (br | jal | jalr) q_res.push_back({pc, exp_taken});
        if (exp_mis) q_redir.push_back(exp_npc);
        @(posedge clk); #1;
        ex_valid = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    endtask

    task automatic wait_idle(output int flush_cycles);
        bit done = 1'b0;
        flush_cycles = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (ex_accept) done = 1'b1;
            else if (flush) flush_cycles++;
        end
        if (!done) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int fc;
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_accept", {31'd0, ex_accept}, 32'd1);
        check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_resolve_valid", {31'd0, resolve_valid}, 32'd0);
        check("rst_resolve_taken", {31'd0, resolve_taken}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_resolve_pc", resolve_pc, 32'd0);
        check("rst_br_cnt", {28'd0, br_cnt}, 32'd0);
        check("rst_mis_cnt", {28'd0, mispred_cnt}, 32'd0);

        funct3 = 3'b110; #1 check("unsigned_110", {31'd0, br_unsigned}, 32'd1);
        funct3 = 3'b101; #1 check("unsigned_101", {31'd0, br_unsigned}, 32'd0);
        funct3 = 3'b011; #1 check("unsigned_011", {31'd0, br_unsigned}, 32'd1);

        // BLTU not taken, correctly predicted
        issue(1, 0, 0, 3'b110, 32'h200, 32'h40, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        #1 check("bltu_no_redirect", {31'd0, redirect_valid}, 32'd0);
        check("bltu_br_cnt", {28'd0, br_cnt}, 32'd1);
        check("bltu_mis_cnt", {28'd0, mispred_cnt}, 32'd0);

        // BEQ taken, predicted not taken
        issue(1, 0, 0, 3'b000, 32'h100, 32'h20, 0, 0, 1, 0, 0, 1'b1, 1'b1, 32'h120);
        check("beq_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("beq_accept_low", {31'd0, ex_accept}, 32'd0);
        check("beq_mis_cnt", {28'd0, mispred_cnt}, 32'd1);
        wait_idle(fc);
        check("beq_flush_cycles", fc, 32'd3);

        // JALR correctly predicted, then mispredicted
        issue(0, 0, 1, 3'b000, 32'h300, 32'h4, 32'h1003, 0, 0, 1, 32'h1006, 1'b1, 1'b0, 0);
        issue(0, 0, 1, 3'b000, 32'h304, 32'h4, 32'h1003, 0, 0, 1, 32'h1008, 1'b1, 1'b1, 32'h1006);
        wait_idle(fc);
        check("jalr_br_cnt", {28'd0, br_cnt}, 32'd4);
        check("jalr_mis_cnt", {28'd0, mispred_cnt}, 32'd2);

        // back-to-back correctly predicted control flow, incl. non-CF and class priority
        issue(1, 0, 0, 3'b001, 32'h400, 32'h40, 0, 0, 1, 0, 0, 1'b0, 1'b0, 0);
        issue(1, 0, 0, 3'b100, 32'h404, 32'h10, 0, 1, 0, 1, 32'h414, 1'b1, 1'b0, 0);
        issue(1, 0, 0, 3'b111, 32'h408, 32'hFFFF_FFF8, 0, 0, 0, 1, 32'h400, 1'b1, 1'b0, 0);
        issue(0, 1, 0, 3'b000, 32'h40C, 32'h100, 0, 0, 0, 1, 32'h50C, 1'b1, 1'b0, 0);
        issue(0, 0, 0, 3'b000, 32'h410, 32'h8, 0, 0, 1, 0, 0, 1'b0, 1'b0, 0);
        issue(1, 0, 0, 3'b011, 32'h410, 32'h8, 0, 1, 1, 1, 32'h414, 1'b0, 1'b0, 0);
        issue(1, 1, 0, 3'b000, 32'h414, 32'h8, 0, 0, 0, 1, 32'h41C, 1'b1, 1'b0, 0);
        @(negedge clk);
        check("b2b_br_cnt", {28'd0, br_cnt}, 32'd10);
        check("b2b_mis_cnt", {28'd0, mispred_cnt}, 32'd2);
        check("b2b_accept", {31'd0, ex_accept}, 32'd1);

        // redirect stalled by ready low; EX inputs must be ignored
        redirect_ready = 1'b0;
        issue(1, 0, 0, 3'b101, 32'h500, 32'h400, 0, 1, 0, 1, 32'h900, 1'b0, 1'b1, 32'h504);
        for (int i = 0; i < 3; i++) begin
            ex_valid = 1'b1; is_jal = 1'b1; ex_pc = 32'h800 + 32'(i); ex_imm = 32'h40; pred_taken = 1'b0;
            @(negedge clk);
            check("stall_accept", {31'd0, ex_accept}, 32'd0);
            check("stall_redirect_valid", {31'd0, redirect_valid}, 32'd1);
            check("stall_br_cnt", {28'd0, br_cnt}, 32'd11);
            check("stall_mis_cnt", {28'd0, mispred_cnt}, 32'd3);
        end
        ex_valid = 1'b0; is_jal = 1'b0;
        redirect_ready = 1'b1;
        wait_idle(fc);

        // saturation with 20 mispredicts
        for (int i = 0; i < 20; i++) begin
            issue(1, 0, 0, 3'b000, 32'h600, 32'h100, 0, 0, 0, 1, 32'h700, 1'b0, 1'b1, 32'h604);
            wait_idle(fc);
        end
        check("sat_br_cnt", {28'd0, br_cnt}, 32'd15);
        check("sat_mis_cnt", {28'd0, mispred_cnt}, 32'd15);

        // clear wins over same-cycle increment
        cnt_clr = 1'b1;
        issue(1, 0, 0, 3'b000, 32'hA00, 32'h10, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        cnt_clr = 1'b0;
        check("clr_br_cnt", {28'd0, br_cnt}, 32'd0);
        check("clr_mis_cnt", {28'd0, mispred_cnt}, 32'd0);
        issue(1, 0, 0, 3'b000, 32'hA04, 32'h10, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        check("post_clr_br_cnt", {28'd0, br_cnt}, 32'd1);

        // asynchronous reset while in FLUSH
        issue(0, 1, 0, 3'b000, 32'hB00, 32'h20, 0, 0, 0, 0, 0, 1'b1, 1'b1, 32'hB20);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_flush", {31'd0, flush}, 32'd1);
        check("pre_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_flush", {31'd0, flush}, 32'd0);
        check("async_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("async_rst_accept", {31'd0, ex_accept}, 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_accept", {31'd0, ex_accept}, 32'd1);
        check("post_rst_br_cnt", {28'd0, br_cnt}, 32'd0);
        check("post_rst_mis_cnt", {28'd0, mispred_cnt}, 32'd0);
        check("post_rst_redirect_pc", redirect_pc, 32'd0);

        repeat (2) @(negedge clk);
        check("res_queue_empty", q_res.size(), 32'd0);
        check("redir_queue_empty", q_redir.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/br_ctrl.md
# br_ctrl

Branch resolution controller for the EX stage of the pipelined RV32I core. It drives the branch comparator's signedness select and consumes its `less`/`equal` flags. From those it resolves conditional branches, JAL and JALR against the fetch-stage prediction carried down the pipe. On a mispredict it sequences the front-end redirect handshake and the pipeline flush, and it keeps saturating branch/mispredict counters for the performance CSRs.

## Interface
- `FLUSH_CYCLES`, default 2: cycles `o_flush` stays high after the redirect handshake completes; 0 is legal.
- `CNT_W`, default 32: width of each performance counter.
- `i_clk`  in  1  clock; the only clock.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_ex_valid`  in  1  EX-stage instruction valid.
- `i_ex_pc`  in  32  PC of the EX instruction.
- `i_ex_imm`  in  32  sign-extended immediate.
- `i_rs1_data`  in  32  rs1 operand, used for the JALR target.
- `i_funct3`  in  3  branch funct3.
- `i_is_branch`, `i_is_jal`, `i_is_jalr`  in  1 each  decoded instruction class.
- `i_pred_taken`  in  1  fetch prediction: taken.
- `i_pred_target`  in  32  fetch predicted target.
- `o_br_unsigned`  out  1  signedness select to the comparator.
- `i_br_less`, `i_br_equal`  in  1 each  comparator flags.
- `o_ex_accept`  out  1  EX instruction consumed this cycle; EX stalls while low.
- `o_redirect_valid`  out  1  redirect request to fetch.
- `o_redirect_pc`  out  32  redirect address.
- `i_redirect_ready`  in  1  fetch accepts the redirect.
- `o_flush`  out  1  kill IF/ID contents.
- `o_resolve_valid`  out  1  one-cycle predictor-update pulse.
- `o_resolve_taken`  out  1  actual direction.
- `o_resolve_pc`  out  32  PC of the resolved instruction.
- `o_br_cnt`  out  CNT_W  resolved control-flow count.
- `o_mispred_cnt`  out  CNT_W  mispredict count.
- `i_cnt_clr`  in  1  synchronous counter clear.

## Operation
- `o_br_unsigned = i_funct3[1]`; purely combinational, valid every cycle.
- Class priority: JALR over JAL over branch.
- Taken by funct3:
  - 000 taken when `equal`; 001 taken when `!equal`.
  - 100 and 110 taken when `less`; 101 and 111 taken when `!less`.
  - 010 and 011 are not taken.
  - JAL and JALR are always taken.
- Target:
  - Branch and JAL: `pc + imm`.
  - JALR: `(rs1 + imm) & ~1`.
  - All additions are mod 2^32.
- Actual next PC = taken ? target : pc+4. Predicted next PC = `i_pred_taken` ? `i_pred_target` : pc+4.
- Mispredict = actual next PC ≠ predicted next PC.
- FSM states: IDLE, REDIRECT, FLUSH.
  - IDLE: `o_ex_accept` = 1. A resolve event is `i_ex_valid` with a control-flow class. On a resolve event, register the `o_resolve_*` outputs and bump the counters. If it mispredicts, latch the actual next PC into `o_redirect_pc` and go to REDIRECT. A valid instruction with no control-flow class is accepted with no effect.
  - REDIRECT: `o_redirect_valid` = 1, `o_flush` = 1, `o_ex_accept` = 0, and `o_redirect_pc` is held stable. On `i_redirect_ready`, go to FLUSH with the counter loaded to FLUSH_CYCLES, or to IDLE if FLUSH_CYCLES is 0.
  - FLUSH: `o_flush` = 1, `o_ex_accept` = 0. Decrement the counter each cycle; go to IDLE when it reaches 1.
- EX inputs are ignored whenever state ≠ IDLE.
- Counters saturate at all-ones. `i_cnt_clr` has priority over a same-cycle increment, and the counters read 0 the next cycle.

## Timing
- Reset state:
  - State IDLE, so `o_ex_accept` = 1.
  - `o_redirect_valid`, `o_flush`, `o_resolve_valid`, `o_resolve_taken` = 0.
  - `o_redirect_pc`, `o_resolve_pc` = 0; both counters = 0.
- Reset asserted mid-operation clears everything asynchronously, including an outstanding redirect.
- Resolve event accepted at edge N:
  - `o_resolve_*` and the counters update at N+1.
  - `o_resolve_valid` stays high for exactly one cycle.
- Mispredict accepted at edge N:
  - `o_redirect_valid` and `o_flush` rise at N+1.
  - The handshake completes at the first edge M where both valid and ready are high.
  - `o_flush` stays high through M+FLUSH_CYCLES.
  - `o_ex_accept` returns to 1 in the cycle after that.
- Back-to-back correctly predicted branches in IDLE resolve one per cycle.

## Test plan
- BEQ, pc=0x100, imm=0x20, equal=1, pred_taken=0 -> `o_redirect_pc`=0x120 from N+1, `o_mispred_cnt`=1, `o_flush` high for 1+2 cycles with ready tied high.
- funct3=110 -> `o_br_unsigned`=1; less=0, pred_taken=0 -> no redirect, `o_resolve_taken`=0, `o_br_cnt`=1, `o_mispred_cnt`=0.
- JALR, rs1=0x1003, imm=0x4, pred 0x1006 taken -> no redirect. Same case with pred 0x1008 -> redirect to 0x1006.
- Mispredict with ready low for 3 cycles -> valid/pc stable, accept=0, new `i_ex_valid` inputs ignored, counters unchanged.
- CNT_W=4, 20 mispredicted branches -> both counters=15. `i_cnt_clr` in the same cycle as a resolve -> counters=0.
- `i_rst_n` low during FLUSH -> flush/redirect drop immediately; after release accept=1 and counters=0.
